fu_alu: RTL and testbench

//  Single-issue integer ALU functional unit. Accepts one issued op at a time.

---
 rtl/fu_alu_if.sv | 38 +++
 rtl/fu_alu.sv | 139 +++++++++++++
 tb/tb_fu_alu.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fu_alu_if.sv
// fu_alu_if: bundles the issue-side request and the register-file port
// signals of the fu_alu functional unit.
//   master : issue logic + external register file (drives requests and read data)
//   slave  : the ALU functional unit
interface fu_alu_if #(
    parameter int SIZE       = 32,
    parameter int REG_NUM    = 8,
    parameter int ALUOP_BITS = 3
);
    localparam int RW = $clog2(REG_NUM);

    // issue side
    logic [ALUOP_BITS-1:0]  ALUOp;
    logic [RW-1:0]          src_reg1;
    logic [RW-1:0]          src_reg2;
    logic                   use_imm;
    logic [SIZE-1:0]        imm;
    logic [RW-1:0]          dest_reg1;
    logic                   issue;

    // register file side
    logic [0:0][RW-1:0]     write_reg;
    logic [0:0][SIZE-1:0]   write_data;
    logic [1:0][RW-1:0]     read_reg;
    logic [1:0][SIZE-1:0]   read_data;
    logic                   RegWrite;
    logic                   Comp;

    modport master (
        output ALUOp, src_reg1, src_reg2, use_imm, imm, dest_reg1, issue, read_data,
        input  write_reg, write_data, read_reg, RegWrite, Comp
    );

    modport slave (
        input  ALUOp, src_reg1, src_reg2, use_imm, imm, dest_reg1, issue, read_data,
        output write_reg, write_data, read_reg, RegWrite, Comp
    );
endinterface

// File: rtl/fu_alu.sv
// fu_alu: single-issue integer ALU functional unit.
// Latches one issued op, reads its sources through the register file's two
// read ports, computes, and writes one result back (IDLE -> EXEC -> WB).
// Optional build macro FU_ALU_OUTREG_EN inserts an extra result stage
// (IDLE -> EXEC -> EXEC2 -> WB), adding one cycle of latency.
module fu_alu #(
    parameter int SIZE       = 32,
    parameter int REG_NUM    = 8,
    parameter int ALUOP_BITS = 3
) (
    input  logic     clk,
    input  logic     rst,
    fu_alu_if.slave  bus
);
    localparam int RW  = $clog2(REG_NUM);
    localparam int SHW = $clog2(SIZE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_EXEC2 = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t state_q, state_d;

    // op fields captured at the issue edge
    logic [ALUOP_BITS-1:0]  op_p0;
    logic [RW-1:0]          src1_p0;
    logic [RW-1:0]          src2_p0;
    logic                   use_imm_p0;
    logic signed [SIZE-1:0] imm_p0;
    logic [RW-1:0]          dest_p0;

    logic signed [SIZE-1:0] opa, opb, alu_out;
    logic signed [SIZE-1:0] res_p1;
    logic signed [SIZE-1:0] res_wb;

    // Shift amount uses only the low log2(SIZE) bits of B; SLT compares signed.
    function automatic logic signed [SIZE-1:0] alu_calc(
        input logic [ALUOP_BITS-1:0]  op,
        input logic signed [SIZE-1:0] a,
        input logic signed [SIZE-1:0] b
    );
        logic signed [SIZE-1:0] r;
        r = '0;
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            3'b101:  r = a << b[SHW-1:0];
            3'b110:  r = a >> b[SHW-1:0];
            3'b111:  r = {{(SIZE-1){1'b0}}, (a < b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    // State register; reset drops any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; issue is only accepted in IDLE, never queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.issue) state_d = S_EXEC;
`ifdef FU_ALU_OUTREG_EN
            S_EXEC:  state_d = S_EXEC2;
`else
            S_EXEC:  state_d = S_WB;
`endif
            S_EXEC2: state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Stage p0: capture the issued op so later input changes cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_p0      <= '0;
            src1_p0    <= '0;
            src2_p0    <= '0;
            use_imm_p0 <= 1'b0;
            imm_p0     <= '0;
            dest_p0    <= '0;
        end else if (state_q == S_IDLE && bus.issue) begin
            op_p0      <= bus.ALUOp;
            src1_p0    <= bus.src_reg1;
            src2_p0    <= bus.src_reg2;
            use_imm_p0 <= bus.use_imm;
            imm_p0     <= bus.imm;
            dest_p0    <= bus.dest_reg1;
        end
    end

    // Operand select and compute during EXEC.
    always_comb begin
        opa     = bus.read_data[0];
        opb     = use_imm_p0 ? imm_p0 : bus.read_data[1];
        alu_out = alu_calc(op_p0, opa, opb);
    end

    // Stage p1: result registered at the end of EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    res_p1 <= '0;
        else if (state_q == S_EXEC) res_p1 <= alu_out;
    end

`ifdef FU_ALU_OUTREG_EN
    logic signed [SIZE-1:0] res_p2;

    // Stage p2: extra output register at the end of EXEC2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     res_p2 <= '0;
        else if (state_q == S_EXEC2) res_p2 <= res_p1;
    end

    assign res_wb = res_p2;
`else
    assign res_wb = res_p1;
`endif

    // Register file drive: live peek of sources in IDLE, latched afterwards;
    // write port and completion are active only in WB.
    always_comb begin
        bus.read_reg[0]   = (state_q == S_IDLE) ? bus.src_reg1 : src1_p0;
        bus.read_reg[1]   = (state_q == S_IDLE) ? bus.src_reg2 : src2_p0;
        bus.RegWrite      = (state_q == S_WB);
        bus.Comp          = (state_q == S_WB);
        bus.write_reg[0]  = (state_q == S_WB) ? dest_p0 : '0;
        bus.write_data[0] = (state_q == S_WB) ? res_wb  : '0;
    end
endmodule

// File: tb/tb_fu_alu.sv
// tb_fu_alu: directed self-checking bench for fu_alu with a behavioural
// 1-write/2-read register file attached to the interface.
module tb_fu_alu;
`ifdef FU_ALU_OUTREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk;
    logic rst;
    logic rf_rst;

    int vectors;
    int miscompares;

    fu_alu_if #(.SIZE(32), .REG_NUM(8), .ALUOP_BITS(3)) bus ();

    fu_alu #(.SIZE(32), .REG_NUM(8), .ALUOP_BITS(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // register file model with a bench-side poke port
    logic [31:0] regs [8];
    logic        poke_en;
    logic [2:0]  poke_idx;
    logic [31:0] poke_val;

    always @(posedge clk) begin
        if (rf_rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= 32'h0;
        end else if (poke_en) begin
            regs[poke_idx] <= poke_val;
        end else if (bus.RegWrite) begin
            regs[bus.write_reg[0]] <= bus.write_data[0];
        end
    end

    assign bus.read_data[0] = regs[bus.read_reg[0]];
    assign bus.read_data[1] = regs[bus.read_reg[1]];

    task automatic poke(input logic [2:0] idx, input logic [31:0] val);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = val;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // Issue one op, optionally change dest after the issue edge, wait for Comp
    // (bounded) and return after the commit edge. lat=0 means no completion.
    task automatic run_op(input logic [2:0] op, input logic [2:0] s1, input logic [2:0] s2,
                          input logic ui, input logic [31:0] im, input logic [2:0] d,
                          input logic [2:0] d_after,
                          output int lat, output logic [31:0] wd, output logic [2:0] wr);
        @(negedge clk);
        bus.ALUOp     = op;
        bus.src_reg1  = s1;
        bus.src_reg2  = s2;
        bus.use_imm   = ui;
        bus.imm       = im;
        bus.dest_reg1 = d;
        bus.issue     = 1'b1;
        @(posedge clk);
        #1;
        bus.issue     = 1'b0;
        bus.dest_reg1 = d_after;
        lat = 0;
        wd  = 32'h0;
        wr  = 3'h0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.Comp) begin
                lat = i;
                wd  = bus.write_data[0];
                wr  = bus.write_reg[0];
                break;
            end
        end
        if (lat != 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rf_rst = 1'b1;
        bus.src_reg1 = 3'd3;
        bus.src_reg2 = 3'd5;
        bus.issue = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.RegWrite !== 1'b0 || bus.Comp !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: RegWrite=%b Comp=%b expected 0 0", bus.RegWrite, bus.Comp);
        end
        vectors++;
        if (bus.write_reg[0] !== 3'd0 || bus.write_data[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_wb: write_reg=%0h write_data=%0h expected 0 0",
                     bus.write_reg[0], bus.write_data[0]);
        end
        vectors++;
        if (bus.read_reg[0] !== 3'd3 || bus.read_reg[1] !== 3'd5) begin
            miscompares++;
            $display("FAIL idle_peek: read_reg=%0d,%0d expected 3,5", bus.read_reg[0], bus.read_reg[1]);
        end
        bus.issue = 1'b0;
        rst = 1'b0;
        rf_rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.Comp !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: Comp=%b expected 0", bus.Comp);
        end
    endtask

    task automatic test_add_basic;
        int lat; logic [31:0] wd; logic [2:0] wr;
        run_op(3'b000, 3'd0, 3'd0, 1'b1, 32'd10, 3'd0, 3'd0, lat, wd, wr);
        vectors++;
        if (lat !== LAT) begin
            miscompares++;
            $display("FAIL t1_latency: got %0d expected %0d", lat, LAT);
        end
        vectors++;
        if (wd !== 32'd10 || wr !== 3'd0) begin
            miscompares++;
            $display("FAIL t1_wb: data=%0h reg=%0d expected a 0", wd, wr);
        end
        vectors++;
        if (bus.Comp !== 1'b0 || bus.RegWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_pulse: Comp=%b RegWrite=%b expected 0 0 after WB", bus.Comp, bus.RegWrite);
        end
        bus.src_reg1 = 3'd0;
        #1;
        vectors++;
        if (bus.read_data[0] !== 32'd10) begin
            miscompares++;
            $display("FAIL t1_peek: read_data0=%0h expected a", bus.read_data[0]);
        end
    endtask

    task automatic test_dest_latch;
        int lat; logic [31:0] wd; logic [2:0] wr;
        run_op(3'b000, 3'd0, 3'd0, 1'b1, 32'd10, 3'd0, 3'd1, lat, wd, wr);
        vectors++;
        if (wr !== 3'd0 || lat !== LAT) begin
            miscompares++;
            $display("FAIL t2_dest: write_reg=%0d lat=%0d expected 0 %0d", wr, lat, LAT);
        end
        vectors++;
        if (regs[0] !== 32'd20 || regs[1] !== 32'd0) begin
            miscompares++;
            $display("FAIL t2_regs: reg0=%0h reg1=%0h expected 14 0", regs[0], regs[1]);
        end
    endtask

    task automatic test_logic_ops;
        int lat; logic [31:0] wd; logic [2:0] wr;
        logic [2:0]  ops  [3] = '{3'b010, 3'b011, 3'b100};
        logic [31:0] exps [3] = '{32'h000F_000F, 32'h0FFF_0FFF, 32'h0FF0_0FF0};
        poke(3'd2, 32'd55);
        run_op(3'b001, 3'd0, 3'd0, 1'b0, 32'h0, 3'd2, 3'd2, lat, wd, wr);
        vectors++;
        if (regs[2] !== 32'd0) begin
            miscompares++;
            $display("FAIL t3_sub_self: reg2=%0h expected 0", regs[2]);
        end
        poke(3'd0, 32'hFFFF_FFFF);
        run_op(3'b111, 3'd0, 3'd0, 1'b1, 32'd1, 3'd3, 3'd3, lat, wd, wr);
        vectors++;
        if (regs[3] !== 32'd1) begin
            miscompares++;
            $display("FAIL t3_slt_neg: reg3=%0h expected 1", regs[3]);
        end
        poke(3'd4, 32'h0F0F_00FF);
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], 3'd4, 3'd0, 1'b1, 32'h00FF_0F0F, 3'(5 + i), 3'(5 + i), lat, wd, wr);
            vectors++;
            if (wd !== exps[i] || regs[5 + i] !== exps[i]) begin
                miscompares++;
                $display("FAIL t3_logic_op%0d: wb=%0h reg=%0h expected %0h", i, wd, regs[5 + i], exps[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int comp_n, rw_n, consec;
        logic prev_rw;
        poke(3'd5, 32'd100);
        comp_n = 0; rw_n = 0; consec = 0; prev_rw = 1'b0;
        bus.ALUOp = 3'b000; bus.src_reg1 = 3'd5; bus.src_reg2 = 3'd0;
        bus.use_imm = 1'b1; bus.imm = 32'd1; bus.dest_reg1 = 3'd5;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (bus.Comp) comp_n++;
                if (bus.RegWrite) rw_n++;
                if (bus.RegWrite && prev_rw) consec++;
                prev_rw = bus.RegWrite;
            end
            if (i == 0) bus.issue = 1'b1;
            if (i == 6) bus.issue = 1'b0;
        end
        vectors++;
        if (comp_n !== 2 || rw_n !== 2) begin
            miscompares++;
            $display("FAIL t4_count: Comp=%0d RegWrite=%0d expected 2 2", comp_n, rw_n);
        end
        vectors++;
        if (consec !== 0) begin
            miscompares++;
            $display("FAIL t4_rw_width: consecutive RegWrite cycles=%0d expected 0", consec);
        end
        vectors++;
        if (regs[5] !== 32'd102) begin
            miscompares++;
            $display("FAIL t4_result: reg5=%0d expected 102", regs[5]);
        end
    endtask

    task automatic test_reset_mid_op;
        int lat; logic [31:0] wd; logic [2:0] wr;
        int rw_seen;
        poke(3'd6, 32'd9);
        @(negedge clk);
        bus.ALUOp = 3'b000; bus.src_reg1 = 3'd0; bus.use_imm = 1'b1;
        bus.imm = 32'd77; bus.dest_reg1 = 3'd6; bus.issue = 1'b1;
        @(posedge clk);
        #1 bus.issue = 1'b0;
        #2 rst = 1'b1;
        rw_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.RegWrite || bus.Comp) rw_seen++;
        end
        vectors++;
        if (rw_seen !== 0 || bus.write_data[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL t5_in_reset: write/comp cycles=%0d data=%0h expected 0 0", rw_seen, bus.write_data[0]);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.RegWrite || bus.Comp) rw_seen++;
        end
        vectors++;
        if (rw_seen !== 0 || regs[6] !== 32'd9) begin
            miscompares++;
            $display("FAIL t5_dropped: write cycles=%0d reg6=%0d expected 0 9", rw_seen, regs[6]);
        end
        run_op(3'b000, 3'd6, 3'd0, 1'b1, 32'd1, 3'd6, 3'd6, lat, wd, wr);
        vectors++;
        if (lat !== LAT || regs[6] !== 32'd10) begin
            miscompares++;
            $display("FAIL t5_recover: lat=%0d reg6=%0d expected %0d 10", lat, regs[6], LAT);
        end
    endtask

    task automatic test_boundaries;
        int lat; logic [31:0] wd; logic [2:0] wr;
        logic [2:0]  op  [5] = '{3'b000, 3'b101, 3'b110, 3'b111, 3'b001};
        logic [2:0]  s1  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
        logic [2:0]  s2  [5] = '{3'd0, 3'd0, 3'd0, 3'd7, 3'd0};
        logic        ui  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] im  [5] = '{32'd1, 32'd33, 32'd31, 32'd0, 32'd1};
        logic [2:0]  dst [5] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd7};
        logic [31:0] exp [5] = '{32'h0, 32'h6, 32'h1, 32'h0, 32'hFFFF_FFFF};
        poke(3'd1, 32'hFFFF_FFFF);
        poke(3'd2, 32'h0000_0003);
        poke(3'd3, 32'h8000_0000);
        poke(3'd4, 32'd5);
        poke(3'd7, 32'hFFFF_FFFD);
        poke(3'd0, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            run_op(op[i], s1[i], s2[i], ui[i], im[i], dst[i], dst[i], lat, wd, wr);
            vectors++;
            if (lat !== LAT || wr !== dst[i] || regs[dst[i]] !== exp[i]) begin
                miscompares++;
                $display("FAIL t6_case%0d: lat=%0d reg%0d=%0h wr=%0d expected lat %0d value %0h",
                         i, lat, dst[i], regs[dst[i]], wr, LAT, exp[i]);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        rf_rst = 1'b1;
        poke_en = 1'b0;
        poke_idx = 3'd0;
        poke_val = 32'h0;
        bus.ALUOp = 3'b000;
        bus.src_reg1 = 3'd0;
        bus.src_reg2 = 3'd0;
        bus.use_imm = 1'b0;
        bus.imm = 32'h0;
        bus.dest_reg1 = 3'd0;
        bus.issue = 1'b0;

        test_reset;
        test_add_basic;
        test_dest_latch;
        test_logic_ops;
        test_back_to_back;
        test_reset_mid_op;
        test_boundaries;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
